// File: rtl/fv_dup_pkg.sv
// Shared types and orig/dup register-pair mapping helpers for the dup-ready scheduler.
package fv_dup_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SYNC = 2'd2,
        ERR  = 2'd3
    } fv_dup_state_t;

    localparam int DEF_NUM_REGS = 32;

    function automatic int num_pairs_of(input int num_regs);
        return num_regs / 2;
    endfunction

    // Lower half of the register file holds originals, upper half their duplicates.
    function automatic int pair_of(input int r, input int num_pairs);
        return (r < num_pairs) ? r : r - num_pairs;
    endfunction

    function automatic logic is_orig(input int r, input int num_pairs);
        return r < num_pairs;
    endfunction

endpackage

// File: rtl/fv_dup_pair_cnt.sv
// Signed saturating orig-minus-dup write counter for one register pair, with sticky overflow.
// Latency: cnt_next/ovf_next are combinational views of the value after the coming edge.
// Backpressure: none; a delta is accepted every cycle.
module fv_dup_pair_cnt #(
    parameter int CNT_W   = 4,
    parameter int DELTA_W = 3
) (
    input  logic                     clk,
    input  logic                     reset_,
    input  logic signed [DELTA_W-1:0] delta,
    output logic signed [CNT_W-1:0]  cnt_next,
    output logic                     ovf_next
);

    localparam logic signed [CNT_W:0] POS_LIM = (CNT_W+1)'((2 ** (CNT_W - 1)) - 1);
    localparam logic signed [CNT_W:0] NEG_LIM = -POS_LIM;

    logic signed [CNT_W-1:0] cnt;
    logic                    ovf;
    logic signed [CNT_W:0]   sum;

    always_comb begin
        sum      = {cnt[CNT_W-1], cnt} + {{(CNT_W + 1 - DELTA_W){delta[DELTA_W-1]}}, delta};
        cnt_next = sum[CNT_W-1:0];
        ovf_next = ovf;
        // Symmetric range: the most negative code is never used so orig and dup clamp alike.
        if (sum > POS_LIM) begin
            cnt_next = POS_LIM[CNT_W-1:0];
            ovf_next = 1'b1;
        end else if (sum < NEG_LIM) begin
            cnt_next = NEG_LIM[CNT_W-1:0];
            ovf_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            cnt <= cnt_next;
            ovf <= ovf_next;
        end
    end

endmodule

// File: rtl/fv_dup_ready_ctrl.sv
// Tracks orig/dup committed writes per register pair and schedules pair/sync equivalence checks.
// Latency: commits sampled at an edge are reflected on the registered outputs right after it.
// Backpressure: none; the commit stream is observed, never stalled.
module fv_dup_ready_ctrl
    import fv_dup_pkg::*;
#(
    parameter int          COMMIT_W  = 2,
    parameter int          NUM_REGS  = DEF_NUM_REGS,
    parameter int          CNT_W     = 4,
    parameter int          SYNC_HOLD = 2,
    parameter logic [63:0] PAIR_MASK = 64'hFFFF_FFFC,
    localparam int         NUM_PAIRS = num_pairs_of(NUM_REGS),
    localparam int         RW        = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset_,
    input  logic [COMMIT_W-1:0]      commit,
    input  logic [COMMIT_W-1:0]      commit_rd_we,
    input  logic [COMMIT_W*RW-1:0]   commit_rd,
    output logic [NUM_PAIRS-1:0]     fv_dup_ready_pairs_1,
    output logic                     fv_dup_ready_1,
    output logic                     fv_dup_sync_ready,
    output logic                     dup_overflow,
    output logic [1:0]               dup_state
);

    localparam int DELTA_W = $clog2(COMMIT_W + 1) + 1;
    localparam int HW      = $clog2(SYNC_HOLD) + 1;
    localparam logic [NUM_PAIRS-1:0] TRACK = PAIR_MASK[NUM_PAIRS-1:0];

    logic signed [DELTA_W-1:0] pair_delta [NUM_PAIRS];
    logic signed [CNT_W-1:0]   cnt_next   [NUM_PAIRS];
    logic [NUM_PAIRS-1:0]      ovf_next;
    logic [NUM_PAIRS-1:0]      balanced;
    logic                      all_bal;
    logic                      any_commit;
    logic                      any_write;
    logic                      quiet;

    fv_dup_state_t             state, state_nxt;
    logic [HW-1:0]             hold, hold_nxt;

    logic [NUM_PAIRS-1:0]      pairs_d;
    logic                      ready_d;
    logic                      sync_d;
    logic                      ovf_d;

    // Lane decode: untracked pairs never see a delta, so they cannot overflow or wake the FSM.
    always_comb begin
        any_commit = |commit;
        any_write  = 1'b0;
        for (int p = 0; p < NUM_PAIRS; p++) begin
            pair_delta[p] = '0;
            for (int l = 0; l < COMMIT_W; l++) begin
                if (commit[l] && commit_rd_we[l] && TRACK[p] &&
                    pair_of(int'(commit_rd[l*RW +: RW]), NUM_PAIRS) == p) begin
                    any_write = 1'b1;
                    if (is_orig(int'(commit_rd[l*RW +: RW]), NUM_PAIRS))
                        pair_delta[p] = pair_delta[p] + DELTA_W'(1);
                    else
                        pair_delta[p] = pair_delta[p] - DELTA_W'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_PAIRS; g++) begin : g_pair
        fv_dup_pair_cnt #(
            .CNT_W   (CNT_W),
            .DELTA_W (DELTA_W)
        ) u_cnt (
            .clk      (clk),
            .reset_   (reset_),
            .delta    (pair_delta[g]),
            .cnt_next (cnt_next[g]),
            .ovf_next (ovf_next[g])
        );
    end

    always_comb begin
        for (int p = 0; p < NUM_PAIRS; p++)
            balanced[p] = TRACK[p] && (cnt_next[p] == '0) && !ovf_next[p];
        all_bal = &(balanced | ~TRACK);
        quiet   = !any_commit && all_bal;
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state <= IDLE;
            hold  <= '0;
        end else begin
            state <= state_nxt;
            hold  <= hold_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold;
        case (state)
            IDLE: if (any_write) state_nxt = RUN;
            RUN: begin
                if (!quiet) begin
                    hold_nxt = '0;
                end else if (hold == HW'(SYNC_HOLD - 1)) begin
                    state_nxt = SYNC;
                    hold_nxt  = '0;
                end else begin
                    hold_nxt = hold + HW'(1);
                end
            end
            SYNC: begin
                state_nxt = RUN;
                hold_nxt  = '0;
            end
            default: ;
        endcase
        if (|ovf_next) begin
            state_nxt = ERR;
            hold_nxt  = '0;
        end
    end

    always_comb begin
        pairs_d = '0;
        ready_d = 1'b0;
        if (state_nxt == RUN || state_nxt == SYNC) begin
            pairs_d = balanced;
            ready_d = all_bal;
        end
        sync_d = (state_nxt == SYNC);
        ovf_d  = |ovf_next;
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            fv_dup_ready_pairs_1 <= '0;
            fv_dup_ready_1       <= 1'b0;
            fv_dup_sync_ready    <= 1'b0;
            dup_overflow         <= 1'b0;
        end else begin
            fv_dup_ready_pairs_1 <= pairs_d;
            fv_dup_ready_1       <= ready_d;
            fv_dup_sync_ready    <= sync_d;
            dup_overflow         <= ovf_d;
        end
    end

    assign dup_state = state;

endmodule

// File: tb/tb_fv_dup_ready_ctrl.sv
// Directed, table-driven bench for fv_dup_ready_ctrl with hand sequences for reset and saturation.
module tb_fv_dup_ready_ctrl;

    localparam logic [1:0]  S_IDLE = 2'd0;
    localparam logic [1:0]  S_RUN  = 2'd1;
    localparam logic [1:0]  S_SYNC = 2'd2;
    localparam logic [1:0]  S_ERR  = 2'd3;
    localparam logic [15:0] ALL    = 16'hFFFC;

    logic        clk = 1'b0;
    logic        reset_;
    logic [1:0]  commit;
    logic [1:0]  commit_rd_we;
    logic [9:0]  commit_rd;
    logic [15:0] fv_dup_ready_pairs_1;
    logic        fv_dup_ready_1;
    logic        fv_dup_sync_ready;
    logic        dup_overflow;
    logic [1:0]  dup_state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fv_dup_ready_ctrl dut (
        .clk                  (clk),
        .reset_               (reset_),
        .commit               (commit),
        .commit_rd_we         (commit_rd_we),
        .commit_rd            (commit_rd),
        .fv_dup_ready_pairs_1 (fv_dup_ready_pairs_1),
        .fv_dup_ready_1       (fv_dup_ready_1),
        .fv_dup_sync_ready    (fv_dup_sync_ready),
        .dup_overflow         (dup_overflow),
        .dup_state            (dup_state)
    );

    typedef struct {
        logic [1:0]  c;
        logic [1:0]  we;
        logic [4:0]  rd0;
        logic [4:0]  rd1;
        logic [15:0] pairs;
        logic        rdy;
        logic        sync;
        logic        ovf;
        logic [1:0]  st;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [1:0] c, input logic [1:0] we, input logic [4:0] rd0,
                       input logic [4:0] rd1, input logic [15:0] pairs, input logic rdy,
                       input logic sync, input logic ovf, input logic [1:0] st);
        vec_t v;
        v.c = c; v.we = we; v.rd0 = rd0; v.rd1 = rd1;
        v.pairs = pairs; v.rdy = rdy; v.sync = sync; v.ovf = ovf; v.st = st;
        vecs.push_back(v);
    endtask

    task automatic cmp(input string what, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", what, act, exp);
        end
    endtask

    task automatic chk(input string name, input logic [15:0] pairs, input logic rdy,
                       input logic sync, input logic ovf, input logic [1:0] st);
        cmp({name, ".pairs"}, fv_dup_ready_pairs_1, pairs);
        cmp({name, ".ready"}, {15'd0, fv_dup_ready_1}, {15'd0, rdy});
        cmp({name, ".sync"},  {15'd0, fv_dup_sync_ready}, {15'd0, sync});
        cmp({name, ".ovf"},   {15'd0, dup_overflow}, {15'd0, ovf});
        cmp({name, ".state"}, {14'd0, dup_state}, {14'd0, st});
    endtask

    task automatic drive(input logic [1:0] c, input logic [1:0] we,
                         input logic [4:0] rd0, input logic [4:0] rd1);
        commit       = c;
        commit_rd_we = we;
        commit_rd    = {rd1, rd0};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic async_reset(input string name);
        drive(2'b00, 2'b00, 5'd0, 5'd0);
        #3;
        reset_ = 1'b0;
        #1;
        chk(name, 16'h0000, 1'b0, 1'b0, 1'b0, S_IDLE);
        #2;
        reset_ = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_ = 1'b0;
        drive(2'b00, 2'b00, 5'd0, 5'd0);
        #12;
        chk("reset", 16'h0000, 1'b0, 1'b0, 1'b0, S_IDLE);
        reset_ = 1'b1;

        for (int i = 0; i < 10; i++)
            add(2'b00, 2'b00, 5'd0, 5'd0, 16'h0000, 1'b0, 1'b0, 1'b0, S_IDLE);
        add(2'b01, 2'b01, 5'd5,  5'd0,  16'hFFDC, 1'b0, 1'b0, 1'b0, S_RUN);
        add(2'b00, 2'b00, 5'd0,  5'd0,  16'hFFDC, 1'b0, 1'b0, 1'b0, S_RUN);
        add(2'b01, 2'b01, 5'd21, 5'd0,  ALL,      1'b1, 1'b0, 1'b0, S_RUN);
        add(2'b11, 2'b11, 5'd7,  5'd23, ALL,      1'b1, 1'b0, 1'b0, S_RUN);
        add(2'b00, 2'b00, 5'd0,  5'd0,  ALL,      1'b1, 1'b0, 1'b0, S_RUN);
        add(2'b00, 2'b00, 5'd0,  5'd0,  ALL,      1'b1, 1'b1, 1'b0, S_SYNC);
        add(2'b00, 2'b00, 5'd0,  5'd0,  ALL,      1'b1, 1'b0, 1'b0, S_RUN);
        add(2'b00, 2'b00, 5'd0,  5'd0,  ALL,      1'b1, 1'b0, 1'b0, S_RUN);
        add(2'b00, 2'b00, 5'd0,  5'd0,  ALL,      1'b1, 1'b1, 1'b0, S_SYNC);
        add(2'b01, 2'b01, 5'd3,  5'd0,  16'hFFF4, 1'b0, 1'b0, 1'b0, S_RUN);
        add(2'b11, 2'b11, 5'd1,  5'd19, ALL,      1'b1, 1'b0, 1'b0, S_RUN);
        add(2'b11, 2'b01, 5'd16, 5'd12, ALL,      1'b1, 1'b0, 1'b0, S_RUN);
        add(2'b00, 2'b01, 5'd10, 5'd0,  ALL,      1'b1, 1'b0, 1'b0, S_RUN);
        add(2'b00, 2'b00, 5'd0,  5'd0,  ALL,      1'b1, 1'b1, 1'b0, S_SYNC);
        for (int i = 0; i < 7; i++)
            add(2'b01, 2'b01, 5'd9, 5'd0, 16'hFDFC, 1'b0, 1'b0, 1'b0, S_RUN);
        add(2'b01, 2'b01, 5'd9,  5'd0,  16'h0000, 1'b0, 1'b0, 1'b1, S_ERR);
        add(2'b00, 2'b00, 5'd0,  5'd0,  16'h0000, 1'b0, 1'b0, 1'b1, S_ERR);
        add(2'b01, 2'b01, 5'd25, 5'd0,  16'h0000, 1'b0, 1'b0, 1'b1, S_ERR);

        foreach (vecs[i]) begin
            drive(vecs[i].c, vecs[i].we, vecs[i].rd0, vecs[i].rd1);
            step();
            chk($sformatf("vec%0d", i), vecs[i].pairs, vecs[i].rdy, vecs[i].sync,
                vecs[i].ovf, vecs[i].st);
        end

        // Asynchronous reset out of ERR clears the sticky overflow.
        async_reset("rst_from_err");
        step();
        chk("idle_after_err", 16'h0000, 1'b0, 1'b0, 1'b0, S_IDLE);

        // Pair 3 at +2 mid-RUN, then async reset: counters must restart from zero.
        drive(2'b11, 2'b11, 5'd3, 5'd3);
        step();
        chk("pair3_plus2", 16'hFFF4, 1'b0, 1'b0, 1'b0, S_RUN);
        async_reset("rst_mid_run");
        step();
        chk("idle_after_run", 16'h0000, 1'b0, 1'b0, 1'b0, S_IDLE);
        drive(2'b01, 2'b01, 5'd19, 5'd0);
        step();
        chk("pair3_minus1", 16'hFFF4, 1'b0, 1'b0, 1'b0, S_RUN);
        drive(2'b10, 2'b10, 5'd0, 5'd3);
        step();
        chk("pair3_zero", ALL, 1'b1, 1'b0, 1'b0, S_RUN);

        // Negative saturation on pair 4 through its duplicate register.
        for (int i = 0; i < 7; i++) begin
            drive(2'b01, 2'b01, 5'd20, 5'd0);
            step();
            chk($sformatf("neg%0d", i), 16'hFFEC, 1'b0, 1'b0, 1'b0, S_RUN);
        end
        drive(2'b01, 2'b01, 5'd20, 5'd0);
        step();
        chk("neg_sat", 16'h0000, 1'b0, 1'b0, 1'b1, S_ERR);
        drive(2'b00, 2'b00, 5'd0, 5'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
